seg_scan_mux: RTL

//  Time-multiplexed driver for a common-anode multi-digit 7-segment display.
//  - Holds a double-buffered packed-BCD value.
//  - Scans one digit at a time at a fixed refresh rate.
//  - Presents the active digit's 4-bit code to the downstream BCD-to-7-segment

---
 rtl/seg_scan_mux_if.sv | 24 ++
 rtl/seg_scan_mux.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// Bus between the value producer, the scanner and the downstream segment decoder.
// load/value/dp_in flow into the scanner; digit/an/dp and the strobes flow out.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic                    load_ack;
  logic                    frame;

  modport master (
    output load, value, dp_in,
    input  digit, an, dp, load_ack, frame
  );

  modport slave (
    input  load, value, dp_in,
    output digit, an, dp, load_ack, frame
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with a double-buffered BCD value.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_mux #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_mux_if.slave bus
);
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  logic                  ack_q, ack_d;
  logic                  frame_q;
  logic                  tick;
  logic                  boundary;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;

  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]  = act_val_q[gi*4 +: 4];
      assign an_d[gi] = !((idx_q == IDX_W'(gi)) && !blank[gi]);
    end
  endgenerate

`ifdef SEG_LZB_EN
  // zero_above[k]: every nibble from k up to the top digit is zero.
  logic [NUM_DIGITS:0] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      assign zero_above[gi] = zero_above[gi+1] && (nib[gi] == 4'h0);
      if (gi == 0) begin : g_units
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = zero_above[gi] && !act_dp_q[gi];
      end
    end
  endgenerate
`else
  assign blank = '0;
`endif

  always_comb begin
    pre_d      = tick ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The active value only swaps at a frame boundary, so a frame never tears.
    if (boundary && bus.load) begin
      act_val_d  = bus.value;
      act_dp_d   = bus.dp_in;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else if (boundary && pend_vld_q) begin
      act_val_d  = pend_val_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
      pend_vld_d = 1'b1;
    end

    digit_d = blank[idx_q] ? 4'hF : nib[idx_q];
    dp_d    = ~act_dp_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      digit_q    <= 4'h0;
      an_q       <= '1;
      dp_q       <= 1'b1;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      ack_q      <= ack_d;
      frame_q    <= boundary;
    end
  end

  assign bus.digit    = digit_q;
  assign bus.an       = an_q;
  assign bus.dp       = dp_q;
  assign bus.load_ack = ack_q;
  assign bus.frame    = frame_q;
endmodule
